// File: rtl/bus_decoder.sv
// bus_decoder: single-master to two-slave address decoder with registered
// slave handshake. Window S0 has priority over S1; unmapped accesses
// complete with an error. Optional watchdog under `BUS_TIMEOUT_EN`.
module bus_decoder #(
  parameter logic [31:0] S0_BASE = 32'h1000,
  parameter logic [31:0] S0_SPAN = 32'h1000,
  parameter logic [31:0] S1_BASE = 32'h2000,
  parameter logic [31:0] S1_SPAN = 32'h100,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] m_addr,
  input  logic [2:0]  m_size,
  input  logic        m_valid,
  input  logic        m_write,
  input  logic [31:0] m_wdata,
  output logic [31:0] m_rdata,
  output logic        m_ready,
  output logic        m_err,
  output logic [31:0] s0_addr,
  output logic [1:0]  s0_size,
  output logic        s0_valid,
  output logic        s0_write,
  output logic [31:0] s0_wdata,
  input  logic [31:0] s0_rdata,
  input  logic        s0_ready,
  output logic [31:0] s1_addr,
  output logic [1:0]  s1_size,
  output logic        s1_valid,
  output logic        s1_write,
  output logic [31:0] s1_wdata,
  input  logic [31:0] s1_rdata,
  input  logic        s1_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [31:0] S0_LAST   = S0_BASE + S0_SPAN - 32'd1;
  localparam logic [31:0] S1_LAST   = S1_BASE + S1_SPAN - 32'd1;
  localparam logic [31:0] UNMAP_VAL = 32'hDEADBEEF;

  logic [1:0]  state_q, state_d;
  logic        sel_q, sel_d;        // 0: S0, 1: S1
  logic [31:0] off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        s0v_q, s0v_d;
  logic        s1v_q, s1v_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;

  logic        hit0_c, hit1_c;
  logic        sel_ready_c;
  logic [31:0] sel_rdata_c;

  // Only the two low size bits are forwarded to the slaves.
  logic unused_size;
  assign unused_size = m_size[2];

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [31:0] TMO_VAL = 32'hBAD0BAD0;
  logic [WD_W-1:0] wdog_q, wdog_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  // Address decode against both windows; S0 wins on overlap.
  always_comb begin
    hit0_c = (m_addr >= S0_BASE) && (m_addr <= S0_LAST);
    hit1_c = (m_addr >= S1_BASE) && (m_addr <= S1_LAST);
  end

  // Response from whichever slave owns the current transaction.
  always_comb begin
    sel_ready_c = sel_q ? s1_ready : s0_ready;
    sel_rdata_c = sel_q ? s1_rdata : s0_rdata;
  end

  // Next-state and next-register computation.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    wdata_d = wdata_q;
    s0v_d   = s0v_q;
    s1v_d   = s1v_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ready_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
    wdog_d  = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        if (m_valid) begin
          size_d  = m_size[1:0];
          write_d = m_write;
          wdata_d = m_wdata;
          if (hit0_c) begin
            sel_d   = 1'b0;
            off_d   = m_addr - S0_BASE;
            s0v_d   = 1'b1;
            state_d = BUSY;
`ifdef BUS_TIMEOUT_EN
            wdog_d  = '0;
`endif
          end else if (hit1_c) begin
            sel_d   = 1'b1;
            off_d   = m_addr - S1_BASE;
            s1v_d   = 1'b1;
            state_d = BUSY;
`ifdef BUS_TIMEOUT_EN
            wdog_d  = '0;
`endif
          end else begin
            rdata_d = UNMAP_VAL;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (sel_ready_c) begin
          rdata_d = sel_rdata_c;
          err_d   = 1'b0;
          s0v_d   = 1'b0;
          s1v_d   = 1'b0;
          state_d = DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (wdog_q == WD_LAST) begin
          rdata_d = TMO_VAL;
          err_d   = 1'b1;
          s0v_d   = 1'b0;
          s1v_d   = 1'b0;
          state_d = DONE;
        end else begin
          wdog_d  = wdog_q + WD_W'(1);
        end
`endif
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        s0v_d   = 1'b0;
        s1v_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      s0v_q   <= 1'b0;
      s1v_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      s0v_q   <= s0v_d;
      s1v_q   <= s1v_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
`ifdef BUS_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign m_rdata  = rdata_q;
  assign m_err    = err_q;
  assign m_ready  = ready_q;

  assign s0_addr  = off_q;
  assign s0_size  = size_q;
  assign s0_valid = s0v_q;
  assign s0_write = write_q;
  assign s0_wdata = wdata_q;

  assign s1_addr  = off_q;
  assign s1_size  = size_q;
  assign s1_valid = s1v_q;
  assign s1_write = write_q;
  assign s1_wdata = wdata_q;

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 SHALL have parameter S0_BASE, default 32'h1000, RAM window base.
REQ-002 SHALL have parameter S0_SPAN, default 32'h1000, RAM window size in bytes.
REQ-003 SHALL have parameter S1_BASE, default 32'h2000, stdio window base.
REQ-004 SHALL have parameter S1_SPAN, default 32'h100, stdio window size in bytes.
REQ-005 SHALL have parameter TIMEOUT, default 255, watchdog limit in cycles.
REQ-006 SHALL have ports: clk in 1, sole clock, rising edge; rstb in 1, asynchronous active-low reset.
REQ-007 SHALL have master-side ports: m_addr in 32; m_size in 3; m_valid in 1; m_write in 1; m_wdata in 32; m_rdata out 32; m_ready out 1; m_err out 1.
REQ-008 SHALL have slave-side ports for each k in {0,1}: sk_addr out 32, byte offset; sk_size out 2; sk_valid out 1; sk_write out 1; sk_wdata out 32; sk_rdata in 32; sk_ready in 1.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-010 In IDLE with m_valid=1, SHALL latch addr, size, write and wdata, and decode the address: S0 if S0_BASE <= addr <= S0_BASE+S0_SPAN-1, else S1 if inside the S1 window, else unmapped.
REQ-011 Mapped decode SHALL go to BUSY; unmapped decode SHALL go to DONE with m_err=1 and m_rdata=32'hDEADBEEF.
REQ-012 In BUSY, SHALL drive the selected sk_valid=1 from registers, with sk_addr = latched addr minus window base (32-bit, no wrap possible inside the window) and sk_size = m_size[1:0]; the unselected slave SHALL see valid=0.
REQ-013 In BUSY, when the selected sk_ready=1, SHALL capture sk_rdata into m_rdata, deassert sk_valid on the next cycle, and go to DONE.
REQ-014 In DONE, SHALL assert m_ready=1 for exactly one cycle, then go to IDLE.
REQ-015 m_rdata and m_err SHALL hold their values until the next DONE.
REQ-016 Minimum master latency SHALL be m_valid in IDLE -> m_ready 3 cycles later for a slave returning ready in its first BUSY cycle.
REQ-017 After DONE, SHALL sample m_valid again in IDLE; a master holding m_valid through DONE therefore starts a new transaction, so the master must drop valid on m_ready.
REQ-018 m_valid deasserting during BUSY SHALL NOT abort the transaction; completion proceeds normally.
REQ-019 Writes SHALL return m_rdata = sk_rdata as captured; the master ignores it.
REQ-020 sk_ready from the unselected slave SHALL be ignored.
REQ-021 Windows overlapping SHALL resolve to S0 (priority).

Reset
REQ-022 rstb=0 SHALL asynchronously force state IDLE, all sk_valid=0, m_ready=0, m_err=0, m_rdata=0, sk_addr/sk_wdata=0, watchdog=0.
REQ-023 Reset during BUSY SHALL drop sk_valid immediately, with no completion reported after release.

Configuration
REQ-024 With BUS_TIMEOUT_EN defined, a counter SHALL clear on entry to BUSY and increment each BUSY cycle without ready; on reaching TIMEOUT it SHALL deassert sk_valid, go to DONE with m_err=1 and m_rdata=32'hBAD0BAD0.
REQ-025 Without BUS_TIMEOUT_EN, BUSY SHALL wait indefinitely for sk_ready, and no counter logic SHALL be synthesized.

Verification
REQ-026 Read 32'h1010, size 2, with s0_ready in the first BUSY cycle and s0_rdata=32'h73686974 -> s0_addr=32'h10, m_ready 3 cycles after valid, m_rdata=32'h73686974, m_err=0.
REQ-027 Write 32'h2004, data 32'h41, s1_ready after 4 cycles -> s1_addr=4, s1_write=1, s1_wdata=32'h41, s0_valid never 1.
REQ-028 Boundaries: 32'h1FFF -> S0 with s0_addr=32'hFFF; 32'h2000 -> S1 with s1_addr=0; 32'h0FFC -> m_err=1, m_rdata=32'hDEADBEEF, no sk_valid.
REQ-029 With BUS_TIMEOUT_EN and TIMEOUT=8, S0 never ready -> m_err=1, m_rdata=32'hBAD0BAD0 after 8 BUSY cycles, s0_valid low after that.
REQ-030 rstb pulsed low in the second BUSY cycle -> s0_valid=0 in the same cycle, no m_ready, then a new read of 32'h1000 completes correctly.
REQ-031 Back-to-back reads 32'h1000 and 32'h1004, with valid dropped on m_ready -> two m_ready pulses, correct data each, no duplicate slave access.
